// File: rtl/pair_avg_sequencer.sv
// Stride-pair averaging sequencer: captures a frame of DEPTH samples, then
// streams the rounded average of buf[i] and buf[i+STRIDE] with backpressure.
module pair_avg_sequencer #(
  parameter int unsigned DW     = 8,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned STRIDE = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NRES = DEPTH - STRIDE;

  generate
    if (STRIDE < 1 || STRIDE >= DEPTH) begin : g_bad_stride
      $error("pair_avg_sequencer: STRIDE must satisfy 1 <= STRIDE < DEPTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] mem [DEPTH];
  logic          wr_en;
  logic          load;
  logic          advance;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_pair;
  logic [DW:0]   sum;
  logic [DW-1:0] avg;
  logic          last_next;

  // Read address of the result being loaded: the displayed index on the first
  // load of a frame, the following index when a handshake advances the stream.
  // Never points past the final pair, so rd_pair stays inside the buffer.
  always_comb begin
    rd_addr   = (out_valid && !out_last) ? rd_idx + AW'(1) : rd_idx;
    rd_pair   = rd_addr + AW'(STRIDE);
    sum       = {1'b0, mem[rd_addr]} + {1'b0, mem[rd_pair]};
    avg       = sum[DW:1] + DW'(sum[0]);
    last_next = (rd_addr == AW'(NRES - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FILL;
      end
      S_FILL: begin
        if (in_valid && in_ready) begin
          wr_en = 1'b1;
          if (wr_idx == AW'(DEPTH - 1)) state_next = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (!out_valid) begin
          load = 1'b1;
        end else if (out_ready) begin
          if (out_last) begin
            state_next = S_DONE;
          end else begin
            load    = 1'b1;
            advance = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Sample buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_data;
  end

  // Indices and status outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx   <= '0;
      rd_idx   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_next == S_FILL);
      busy     <= (state_next != S_IDLE);
      done     <= (state_next == S_DONE);
      if (state == S_IDLE)                               wr_idx <= '0;
      else if (wr_en && wr_idx != AW'(DEPTH - 1))        wr_idx <= wr_idx + AW'(1);
      if (state == S_FILL)                               rd_idx <= '0;
      else if (advance)                                  rd_idx <= rd_idx + AW'(1);
    end
  end

  // Result register; holds while stalled, drops valid after the final handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= avg;
      out_last  <= last_next;
    end else if (state_next == S_DONE) begin
      out_valid <= 1'b0;
    end
  end

endmodule
